instr_fetch: RTL

Instruction fetch and sequencing unit: drives the instruction-memory address, presents one instruction per cycle to the control decoder, and computes the next PC from the decoder/datapath branch result. It owns the program counter, a loadable branch-target lookup table (LUT), program start/done handshaking and a cycle counter for benchmarking.

---
 rtl/instr_fetch.sv | 109 ++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch and sequencing: owns the PC, a write-protected branch-target LUT,
// start/done handshaking and a saturating run-cycle counter.
module instr_fetch #(
  parameter int unsigned PC_W     = 10,
  parameter int unsigned INSTR_W  = 9,
  parameter int unsigned LUT_W    = 5,
  parameter int unsigned PROG_LEN = 1024,
  parameter int unsigned CNT_W    = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_lut_we,
  input  logic [LUT_W-1:0]   i_lut_addr,
  input  logic [PC_W-1:0]    i_lut_data,
  output logic [PC_W-1:0]    o_imem_addr,
  input  logic [INSTR_W-1:0] i_imem_data,
  output logic [INSTR_W-1:0] o_instr,
  output logic               o_instr_valid,
  input  logic               i_branch_taken,
  input  logic [LUT_W-1:0]   i_branch_idx,
  output logic [PC_W-1:0]    o_pc,
  output logic               o_done,
  output logic [CNT_W-1:0]   o_cycle_count
);

  localparam int unsigned  LutDepth = 2 ** LUT_W;
  localparam logic [PC_W:0] ProgEnd = (PC_W + 1)'(PROG_LEN);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e             r_state;
  state_e             w_state_nxt;
  logic [PC_W-1:0]    r_pc;
  logic [PC_W-1:0]    w_pc_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [PC_W-1:0]    r_lut [LutDepth];
  logic [PC_W:0]      w_next_pc;
  logic               w_lut_wr;

  // One extra bit so a target or increment at/after PROG_LEN is detected, not wrapped.
  assign w_next_pc = i_branch_taken ? {1'b0, r_lut[i_branch_idx]}
                                    : {1'b0, r_pc} + (PC_W + 1)'(1);

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_cnt_nxt     = r_cnt;
    w_lut_wr      = 1'b0;
    o_instr_valid = 1'b0;
    o_done        = 1'b0;
    unique case (r_state)
      StIdle, StDone: begin
        o_done   = (r_state == StDone);
        w_lut_wr = i_lut_we;
        if (i_start) begin
          w_state_nxt = StRun;
          w_pc_nxt    = '0;
          w_cnt_nxt   = '0;
        end
      end
      StRun: begin
        o_instr_valid = 1'b1;
        if (r_cnt != '1) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
        if (w_next_pc >= ProgEnd) begin
          w_state_nxt = StDone;
        end else begin
          w_pc_nxt = w_next_pc[PC_W-1:0];
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StIdle;
      r_pc    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int unsigned i = 0; i < LutDepth; i++) begin
        r_lut[i] <= '0;
      end
    end else if (w_lut_wr) begin
      r_lut[i_lut_addr] <= i_lut_data;
    end
  end

  assign o_imem_addr   = r_pc;
  assign o_pc          = r_pc;
  assign o_instr       = i_imem_data;
  assign o_cycle_count = r_cnt;

endmodule
